cmd_dispatch_v2: RTL

Parametrised command dispatcher between the UART command aggregator and the shared SPI master.
- Decodes 24-bit commands and issues one SPI transaction to the selected analog-gain channel, trigger DAC or EEPROM.
- Returns a one-byte response (ACK, NACK or EEPROM read data) through a full send/sent handshake.
- Unlike the first-generation dispatcher, it has:
  - a configurable channel count;
  - registered outputs;
  - NACK for unknown opcodes and out-of-range channels;
  - a blocking response handshake;
  - an optional SPI watchdog.

---
 rtl/cmd_dispatch_v2.sv | 325 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cmd_dispatch_v2.sv
// -----------------------------------------------------------------------------
// cmd_dispatch_v2
//
// Command dispatcher sitting between the UART command aggregator and the
// shared SPI master. Decodes a 24-bit command and issues exactly one SPI
// transaction to one of:
//   - a gain channel,
//   - the trigger DAC, or
//   - the EEPROM.
// It then returns a single response byte (ACK, NACK or EEPROM read data)
// through a send/sent handshake. Every output comes straight from a
// flip-flop; there is no combinational path from any input to any output.
//
// Parameters
//   NUM_CH   number of analog gain channels (legal 1..4)
//   TMO_CYC  SPI watchdog limit in clk cycles (only with CMD_TIMEOUT_EN)
//
// Optional feature (compile-time macro)
//   CMD_TIMEOUT_EN  when defined, a watchdog aborts a transaction whose
//                   SPI_done never arrives and answers NACK. When not
//                   defined, XFER waits for SPI_done indefinitely.
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   cmd          in   [23:16] opcode, [15:0] payload
//   cmd_rdy      in   command valid (level, held until cleared)
//   clr_cmd_rdy  out  one-cycle pulse: cmd has been consumed
//   resp_data    out  response byte, stable from send_resp to next response
//   send_resp    out  one-cycle pulse: transmit resp_data
//   resp_sent    in   UART transmit complete
//   ss           out  one-hot slave select
//                       [NUM_CH-1:0] gain channels
//                       [NUM_CH]     trigger DAC
//                       [NUM_CH+1]   EEPROM
//   wrt_SPI      out  one-cycle pulse: start the SPI transaction
//   SPI_data     out  SPI word, held for the whole transaction
//   EEP_data     in   EEPROM read byte, valid while SPI_done is high
//   SPI_done     in   one-cycle pulse: transaction complete
// -----------------------------------------------------------------------------
module cmd_dispatch_v2 #(
  parameter int unsigned NUM_CH  = 3,
  parameter int unsigned TMO_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [23:0]       cmd,
  input  logic              cmd_rdy,
  output logic              clr_cmd_rdy,
  output logic [7:0]        resp_data,
  output logic              send_resp,
  input  logic              resp_sent,
  output logic [NUM_CH+1:0] ss,
  output logic              wrt_SPI,
  output logic [15:0]       SPI_data,
  input  logic [7:0]        EEP_data,
  input  logic              SPI_done
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int unsigned SS_W     = NUM_CH + 2;
  localparam int unsigned TRIG_BIT = NUM_CH;
  localparam int unsigned EEP_BIT  = NUM_CH + 1;

  localparam logic [7:0] OP_CONFIG_GAIN  = 8'h02;
  localparam logic [7:0] OP_SET_TRIGGER  = 8'h03;
  localparam logic [7:0] OP_WRITE_EEPROM = 8'h08;
  localparam logic [7:0] OP_READ_EEPROM  = 8'h09;

  localparam logic [7:0] RESP_ACK  = 8'hA5;
  localparam logic [7:0] RESP_NACK = 8'hEE;

  // Command byte shared by the gain amplifiers and the trigger DAC.
  localparam logic [7:0] DAC_CMD = 8'h13;

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_WAIT_SENT
  } state_e;

  // Gain setting -> DAC code for the gain amplifiers.
  function automatic logic [7:0] gain_code(input logic [2:0] gain);
    logic [7:0] code;
    case (gain)
      3'd0:    code = 8'h02;
      3'd1:    code = 8'h05;
      3'd2:    code = 8'h09;
      3'd3:    code = 8'h14;
      3'd4:    code = 8'h28;
      3'd5:    code = 8'h46;
      3'd6:    code = 8'h6B;
      default: code = 8'hDD;
    endcase
    return code;
  endfunction

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic              clr_q, clr_d;
  logic              wrt_q, wrt_d;
  logic              send_q, send_d;
  logic [SS_W-1:0]   ss_q, ss_d;
  logic [15:0]       spi_q, spi_d;
  logic [7:0]        resp_q, resp_d;
  logic              rd_q, rd_d;   // current transaction is an EEPROM read

  assign clr_cmd_rdy = clr_q;
  assign wrt_SPI     = wrt_q;
  assign send_resp   = send_q;
  assign ss          = ss_q;
  assign SPI_data    = spi_q;
  assign resp_data   = resp_q;

  // ---------------------------------------------------------------------------
  // Command decode (pure function of cmd)
  // ---------------------------------------------------------------------------
  logic [7:0]      opcode;
  logic [1:0]      gain_ch;
  logic [2:0]      gain_sel;
  logic            dec_valid;
  logic            dec_read;
  logic [SS_W-1:0] dec_ss;
  logic [15:0]     dec_word;

  assign opcode   = cmd[23:16];
  assign gain_ch  = cmd[9:8];
  assign gain_sel = cmd[12:10];

  // NOTE: every variable assigned in an always_comb gets a default at the
  // top so that no path leaves it unassigned and a latch can never be inferred.
  always_comb begin
    dec_valid = 1'b0;
    dec_read  = 1'b0;
    dec_ss    = '0;
    dec_word  = '0;
    case (opcode)
      OP_CONFIG_GAIN: begin
        // A channel beyond the configured count is rejected, not aliased.
        if (32'(gain_ch) < NUM_CH) begin
          dec_valid = 1'b1;
          dec_ss    = SS_W'(1) << gain_ch;
          dec_word  = {DAC_CMD, gain_code(gain_sel)};
        end
      end
      OP_SET_TRIGGER: begin
        dec_valid        = 1'b1;
        dec_ss[TRIG_BIT] = 1'b1;
        dec_word         = {DAC_CMD, cmd[7:0]};
      end
      OP_WRITE_EEPROM: begin
        dec_valid       = 1'b1;
        dec_ss[EEP_BIT] = 1'b1;
        dec_word        = {2'b01, cmd[13:0]};
      end
      OP_READ_EEPROM: begin
        dec_valid       = 1'b1;
        dec_read        = 1'b1;
        dec_ss[EEP_BIT] = 1'b1;
        dec_word        = {2'b00, cmd[13:8], 8'h00};
      end
      default: ;
    endcase
  end

  // SPI_done is only meaningful after the cycle that launched the transfer;
  // a pulse coincident with wrt_SPI belongs to some earlier activity.
  logic done_ok;
  assign done_ok = SPI_done && !wrt_q;

  // ---------------------------------------------------------------------------
  // Optional SPI watchdog
  // ---------------------------------------------------------------------------
  logic tmo_hit;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC + 1) : 1;

  logic [TMO_W-1:0] cnt_q, cnt_d;

  // The counter holds the number of XFER cycles already completed. The
  // limit is reached when the cycle in progress would make it TMO_CYC, so
  // the NACK leaves exactly TMO_CYC cycles after wrt_SPI.
  assign tmo_hit = (state_q == S_XFER) && (cnt_q == TMO_W'(TMO_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (state_q == S_XFER) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  logic unused_cmd_bits;
  assign unused_cmd_bits = ^cmd[15:14];
`else
  assign tmo_hit = 1'b0;

  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{cmd[15:14], TMO_CYC};
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register (also holds every registered output)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated only with non-blocking assignments so
  // that every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      clr_q   <= 1'b0;
      wrt_q   <= 1'b0;
      send_q  <= 1'b0;
      ss_q    <= '0;
      spi_q   <= '0;
      resp_q  <= '0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      wrt_q   <= wrt_d;
      send_q  <= send_d;
      ss_q    <= ss_d;
      spi_q   <= spi_d;
      resp_q  <= resp_d;
      rd_q    <= rd_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_rdy) begin
          state_d = dec_valid ? S_XFER : S_WAIT_SENT;
        end
      end
      S_XFER: begin
        if (done_ok || tmo_hit) begin
          state_d = S_WAIT_SENT;
        end
      end
      S_WAIT_SENT: begin
        if (resp_sent) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (next values of the registered outputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    // Pulses default low; held values default to their current contents.
    clr_d  = 1'b0;
    wrt_d  = 1'b0;
    send_d = 1'b0;
    ss_d   = ss_q;
    spi_d  = spi_q;
    resp_d = resp_q;
    rd_d   = rd_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_rdy) begin
          clr_d = 1'b1;
          if (dec_valid) begin
            wrt_d = 1'b1;
            ss_d  = dec_ss;
            spi_d = dec_word;
            rd_d  = dec_read;
          end else begin
            // Rejected command: answer straight away, touch nothing on SPI.
            ss_d   = '0;
            send_d = 1'b1;
            resp_d = RESP_NACK;
          end
        end
      end
      S_XFER: begin
        // A real completion takes priority over a watchdog expiry.
        if (done_ok) begin
          ss_d   = '0;
          send_d = 1'b1;
          resp_d = rd_q ? EEP_data : RESP_ACK;
        end else if (tmo_hit) begin
          ss_d   = '0;
          send_d = 1'b1;
          resp_d = RESP_NACK;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_ss_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(ss_q));

  a_wrt_in_xfer : assert property (@(posedge clk) disable iff (!rst_n)
    wrt_q |-> (state_q == S_XFER) && (ss_q != '0));

  a_send_in_wait : assert property (@(posedge clk) disable iff (!rst_n)
    send_q |-> (state_q == S_WAIT_SENT) && (ss_q == '0));

endmodule
